// File: rtl/seizure_detect_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seizure_pkg
// Shared definitions for the seizure detection controller:
//   - FSM state encodings (also driven out on the state port)
//   - config register addresses
//   - config register reset defaults
//   - at_least_one(): maps a zero count setting to 1
// -----------------------------------------------------------------------------
package seizure_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_WARMUP  = 3'd2,
    S_MONITOR = 3'd3,
    S_ALARM   = 3'd4,
    S_REFRACT = 3'd5
  } state_t;

  localparam logic [1:0] CFG_THR     = 2'd0;
  localparam logic [1:0] CFG_PERSIST = 2'd1;
  localparam logic [1:0] CFG_CLR     = 2'd2;
  localparam logic [1:0] CFG_REFRACT = 2'd3;

  localparam logic [7:0]  PERSIST_DEF     = 8'd4;
  localparam logic [7:0]  CLR_PERSIST_DEF = 8'd8;
  localparam logic [15:0] REFRACT_DEF     = 16'd256;

  // A programmed count of 0 behaves exactly like a count of 1.
  function automatic logic [15:0] at_least_one(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/seizure_detect_ctrl_if.sv
// -----------------------------------------------------------------------------
// seizure_detect_ctrl_if
// Groups the controller's control, sample, config and status signals.
//   master : the environment (drives start/stop/samples/config, reads status)
//   slave  : the controller
// Signals:
//   start, stop           control pulses
//   sample_valid          one-cycle strobe per datapath sample
//   weight_sum            signed weighted sum, valid with sample_valid
//   base_valid            baseline data_valid flags, one per feature
//   cfg_wr/addr/wdata     config write port
//   cfg_ready, cfg_err    config status
//   dp_en_n, dp_clr       datapath enable (active low) and clear
//   alarm, alarm_cnt      alarm level and saturating alarm count
//   state                 current FSM state code
// -----------------------------------------------------------------------------
interface seizure_detect_ctrl_if #(
  parameter int SUM_W = 12,
  parameter int NFEAT = 6
);
  logic                    start;
  logic                    stop;
  logic                    sample_valid;
  logic signed [SUM_W-1:0] weight_sum;
  logic [NFEAT-1:0]        base_valid;
  logic                    cfg_wr;
  logic [1:0]              cfg_addr;
  logic [15:0]             cfg_wdata;
  logic                    cfg_ready;
  logic                    cfg_err;
  logic                    dp_en_n;
  logic                    dp_clr;
  logic                    alarm;
  logic [7:0]              alarm_cnt;
  logic [2:0]              state;

  modport master (
    output start, stop, sample_valid, weight_sum, base_valid,
    output cfg_wr, cfg_addr, cfg_wdata,
    input  cfg_ready, cfg_err, dp_en_n, dp_clr, alarm, alarm_cnt, state
  );

  modport slave (
    input  start, stop, sample_valid, weight_sum, base_valid,
    input  cfg_wr, cfg_addr, cfg_wdata,
    output cfg_ready, cfg_err, dp_en_n, dp_clr, alarm, alarm_cnt, state
  );
endinterface

// File: rtl/seizure_detect_ctrl_cfg_regs.sv
// -----------------------------------------------------------------------------
// detect_cfg_regs
// Four-entry configuration register file. Writes land only while the
// controller is idle; a write attempted at any other time is dropped and
// answered with a one-cycle cfg_err_o pulse.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   idle_i          controller is in IDLE (write enable gate)
//   cfg_wr_i        write strobe
//   cfg_addr_i      register select (CFG_THR/PERSIST/CLR/REFRACT)
//   cfg_wdata_i     write data
//   thr_o           signed alarm threshold
//   persist_o       consecutive over-threshold samples to raise alarm
//   clr_persist_o   consecutive under-threshold samples to clear alarm
//   refract_o       samples ignored after an alarm clears
//   cfg_err_o       dropped-write pulse
// -----------------------------------------------------------------------------
module detect_cfg_regs
  import seizure_pkg::*;
#(
  parameter int SUM_W   = 12,
  parameter int THR_DEF = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    idle_i,
  input  logic                    cfg_wr_i,
  input  logic [1:0]              cfg_addr_i,
  input  logic [15:0]             cfg_wdata_i,
  output logic signed [SUM_W-1:0] thr_o,
  output logic [7:0]              persist_o,
  output logic [7:0]              clr_persist_o,
  output logic [15:0]             refract_o,
  output logic                    cfg_err_o
);

  localparam logic signed [SUM_W-1:0] THR_RST = SUM_W'(THR_DEF);

  logic signed [SUM_W-1:0] thr_q;
  logic [7:0]              persist_q;
  logic [7:0]              clr_persist_q;
  logic [15:0]             refract_q;
  logic                    cfg_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thr_q         <= THR_RST;
      persist_q     <= PERSIST_DEF;
      clr_persist_q <= CLR_PERSIST_DEF;
      refract_q     <= REFRACT_DEF;
      cfg_err_q     <= 1'b0;
    end else begin
      cfg_err_q <= cfg_wr_i & ~idle_i;
      if (cfg_wr_i && idle_i) begin
        unique case (cfg_addr_i)
          CFG_THR:     thr_q         <= $signed(cfg_wdata_i[SUM_W-1:0]);
          CFG_PERSIST: persist_q     <= cfg_wdata_i[7:0];
          CFG_CLR:     clr_persist_q <= cfg_wdata_i[7:0];
          CFG_REFRACT: refract_q     <= cfg_wdata_i;
          default:     ;
        endcase
      end
    end
  end

  assign thr_o         = thr_q;
  assign persist_o     = persist_q;
  assign clr_persist_o = clr_persist_q;
  assign refract_o     = refract_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: rtl/seizure_detect_ctrl.sv
// -----------------------------------------------------------------------------
// seizure_detect_ctrl
// Sequences a single-channel feature datapath: flush, baseline warm-up,
// then over-threshold persistence detection with alarm, clear hysteresis
// and a refractory period. All outputs are registered.
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   seizure_detect_ctrl_if.slave (control, samples, config, status)
// -----------------------------------------------------------------------------
module seizure_detect_ctrl
  import seizure_pkg::*;
#(
  parameter int SUM_W      = 12,
  parameter int NFEAT      = 6,
  parameter int FLUSH_CYC  = 64,
  parameter int WARMUP_MIN = 1024,
  parameter int THR_DEF    = 0
) (
  input logic                 clk,
  input logic                 rst,
  seizure_detect_ctrl_if.slave bus
);

  localparam int FLW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int WW  = $clog2(WARMUP_MIN + 1);
  localparam logic [FLW-1:0]   FLUSH_LAST = FLW'(FLUSH_CYC - 1);
  localparam logic [WW-1:0]    WARM_DONE  = WW'(WARMUP_MIN);
  localparam logic [NFEAT-1:0] ALL_BASE   = '1;

  logic signed [SUM_W-1:0] thr;
  logic [7:0]              persist;
  logic [7:0]              clr_persist;
  logic [15:0]             refract;
  logic                    cfg_err;

  state_t         state_q;
  logic [FLW-1:0] flush_q;
  logic [WW-1:0]  warm_q;
  logic [7:0]     hit_q;
  logic [7:0]     clr_q;
  logic [15:0]    ref_q;
  logic           alarm_q;
  logic [7:0]     alarm_cnt_q;
  logic           dp_en_n_q;
  logic           dp_clr_q;
  logic           cfg_ready_q;

  // cfg_ready_q mirrors "state is IDLE", so it doubles as the write gate.
  detect_cfg_regs #(
    .SUM_W   (SUM_W),
    .THR_DEF (THR_DEF)
  ) u_cfg (
    .clk           (clk),
    .rst           (rst),
    .idle_i        (cfg_ready_q),
    .cfg_wr_i      (bus.cfg_wr),
    .cfg_addr_i    (bus.cfg_addr),
    .cfg_wdata_i   (bus.cfg_wdata),
    .thr_o         (thr),
    .persist_o     (persist),
    .clr_persist_o (clr_persist),
    .refract_o     (refract),
    .cfg_err_o     (cfg_err)
  );

  logic        base_ok;
  logic        in_run;
  logic        ge_thr;
  logic [7:0]  hit_d;
  logic [7:0]  clr_d;
  logic [15:0] ref_d;
  logic [WW-1:0] warm_d;
  logic [15:0] persist_eff;
  logic [15:0] clr_eff;
  logic [15:0] refract_eff;

  // Candidate counter values for the current sample; the FSM decides
  // whether to commit them.
  always_comb begin
    base_ok     = (bus.base_valid == ALL_BASE);
    in_run      = (state_q == S_MONITOR) || (state_q == S_ALARM) ||
                  (state_q == S_REFRACT);
    ge_thr      = (bus.weight_sum >= thr);
    hit_d       = ge_thr ? ((hit_q == 8'hFF) ? hit_q : hit_q + 8'd1) : 8'd0;
    clr_d       = ge_thr ? 8'd0 : ((clr_q == 8'hFF) ? clr_q : clr_q + 8'd1);
    ref_d       = (ref_q == 16'hFFFF) ? ref_q : ref_q + 16'd1;
    warm_d      = (warm_q == WARM_DONE) ? warm_q : warm_q + WW'(bus.sample_valid);
    persist_eff = at_least_one({8'd0, persist});
    clr_eff     = at_least_one({8'd0, clr_persist});
    refract_eff = at_least_one(refract);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      flush_q     <= '0;
      warm_q      <= '0;
      hit_q       <= 8'd0;
      clr_q       <= 8'd0;
      ref_q       <= 16'd0;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= 8'd0;
      dp_en_n_q   <= 1'b1;
      dp_clr_q    <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else if (bus.stop) begin
      // stop outranks everything, including a simultaneous start
      state_q     <= S_IDLE;
      alarm_q     <= 1'b0;
      dp_en_n_q   <= 1'b1;
      dp_clr_q    <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else if (in_run && !base_ok) begin
      // Baseline lost: re-warm from scratch, alarm history kept
      state_q <= S_WARMUP;
      alarm_q <= 1'b0;
      warm_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q     <= S_FLUSH;
            dp_clr_q    <= 1'b1;
            dp_en_n_q   <= 1'b1;
            cfg_ready_q <= 1'b0;
            alarm_cnt_q <= 8'd0;
            flush_q     <= '0;
            warm_q      <= '0;
            hit_q       <= 8'd0;
            clr_q       <= 8'd0;
            ref_q       <= 16'd0;
          end
        end
        S_FLUSH: begin
          if (flush_q == FLUSH_LAST) begin
            state_q   <= S_WARMUP;
            dp_clr_q  <= 1'b0;
            dp_en_n_q <= 1'b0;
          end else begin
            flush_q <= flush_q + 1'b1;
          end
        end
        S_WARMUP: begin
          warm_q <= warm_d;
          if ((warm_d == WARM_DONE) && base_ok) begin
            state_q <= S_MONITOR;
            hit_q   <= 8'd0;
          end
        end
        S_MONITOR: begin
          if (bus.sample_valid) begin
            hit_q <= hit_d;
            if ({8'd0, hit_d} >= persist_eff) begin
              state_q     <= S_ALARM;
              alarm_q     <= 1'b1;
              alarm_cnt_q <= (alarm_cnt_q == 8'hFF) ? alarm_cnt_q : alarm_cnt_q + 8'd1;
              clr_q       <= 8'd0;
            end
          end
        end
        S_ALARM: begin
          if (bus.sample_valid) begin
            clr_q <= clr_d;
            if ({8'd0, clr_d} >= clr_eff) begin
              state_q <= S_REFRACT;
              alarm_q <= 1'b0;
              ref_q   <= 16'd0;
            end
          end
        end
        S_REFRACT: begin
          if (bus.sample_valid) begin
            ref_q <= ref_d;
            if (ref_d >= refract_eff) begin
              state_q <= S_MONITOR;
              hit_q   <= 8'd0;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          alarm_q     <= 1'b0;
          dp_en_n_q   <= 1'b1;
          dp_clr_q    <= 1'b0;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.alarm     = alarm_q;
  assign bus.alarm_cnt = alarm_cnt_q;
  assign bus.dp_en_n   = dp_en_n_q;
  assign bus.dp_clr    = dp_clr_q;
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cfg_err   = cfg_err;

endmodule

// File: tb/tb_seizure_detect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seizure_detect_ctrl
// Directed stimulus with hand-computed expectations. The stimulus process
// queues each expected output value tagged with the cycle it must appear in;
// an independent monitor compares the DUT against the queue on every
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_seizure_detect_ctrl;
  import seizure_pkg::*;

  localparam int SUM_W = 12;
  localparam int NFEAT = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seizure_detect_ctrl_if #(.SUM_W(SUM_W), .NFEAT(NFEAT)) bus ();

  seizure_detect_ctrl #(
    .SUM_W      (SUM_W),
    .NFEAT      (NFEAT),
    .FLUSH_CYC  (64),
    .WARMUP_MIN (1024),
    .THR_DEF    (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {F_STATE, F_ALARM, F_CNT, F_EN_N, F_CLR, F_READY, F_ERR} fld_t;

  typedef struct {
    int    cyc;
    fld_t  fld;
    int    val;
    string name;
  } chk_t;

  chk_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(fld_t f);
    case (f)
      F_STATE: return int'(bus.state);
      F_ALARM: return int'(bus.alarm);
      F_CNT:   return int'(bus.alarm_cnt);
      F_EN_N:  return int'(bus.dp_en_n);
      F_CLR:   return int'(bus.dp_clr);
      F_READY: return int'(bus.cfg_ready);
      default: return int'(bus.cfg_err);
    endcase
  endfunction

  // Monitor: compare every queued expectation whose cycle has come.
  always @(negedge clk) begin : mon
    int i;
    int a;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc <= cyc) begin
        a = actual(q[i].fld);
        checks++;
        if (q[i].cyc != cyc || a != q[i].val) begin
          errors++;
          $display("FAIL %s at cycle %0d: got %0d, expected %0d (due cycle %0d)",
                   q[i].name, cyc, a, q[i].val, q[i].cyc);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic exp_at(fld_t f, int v, string n, int d);
    chk_t c;
    c.cyc  = cyc + d;
    c.fld  = f;
    c.val  = v;
    c.name = n;
    q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(int s);
    bus.weight_sum   = s[SUM_W-1:0];
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    tick();
  endtask

  task automatic cfg_write(logic [1:0] a, logic [15:0] d);
    bus.cfg_wr    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_wr    = 1'b0;
  endtask

  // Start pulse; optional thr write in the same cycle. Ends in WARMUP.
  task automatic start_run(logic with_thr, logic [15:0] thr_val);
    bus.start     = 1'b1;
    bus.cfg_wr    = with_thr;
    bus.cfg_addr  = CFG_THR;
    bus.cfg_wdata = thr_val;
    exp_at(F_STATE, int'(S_FLUSH), "start_state", 1);
    exp_at(F_CLR,   1, "flush_clr_first", 1);
    exp_at(F_EN_N,  1, "flush_en_n", 1);
    exp_at(F_READY, 0, "flush_ready", 1);
    exp_at(F_CNT,   0, "start_cnt_clear", 1);
    exp_at(F_ERR,   0, "start_cfg_no_err", 1);
    tick();
    bus.start  = 1'b0;
    bus.cfg_wr = 1'b0;
    exp_at(F_CLR,   1, "flush_clr_last", 63);
    exp_at(F_STATE, int'(S_FLUSH), "flush_state_last", 63);
    exp_at(F_STATE, int'(S_WARMUP), "warmup_entry", 64);
    exp_at(F_CLR,   0, "warmup_clr_low", 64);
    exp_at(F_EN_N,  0, "warmup_en", 64);
    repeat (64) tick();
  endtask

  task automatic do_warmup();
    for (int i = 1; i <= 1024; i++) begin
      if (i == 1023) exp_at(F_STATE, int'(S_WARMUP), "warm_1023", 1);
      if (i == 1024) exp_at(F_STATE, int'(S_MONITOR), "warm_to_monitor", 1);
      strobe(0);
    end
  endtask

  int t3[7]  = '{120, 130, 90, 110, 110, 110, 110};
  int t4[12] = '{50, 50, 50, 100, 50, 50, 50, -2000, 50, 50, 50, 50};

  initial begin
    bus.start = 0; bus.stop = 0; bus.sample_valid = 0; bus.weight_sum = '0;
    bus.base_valid = 6'h3F; bus.cfg_wr = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;

    // Power-on reset values
    tick();
    exp_at(F_STATE, 0, "rst_state", 0);
    exp_at(F_EN_N,  1, "rst_en_n", 0);
    exp_at(F_CLR,   0, "rst_clr", 0);
    exp_at(F_ALARM, 0, "rst_alarm", 0);
    exp_at(F_CNT,   0, "rst_cnt", 0);
    exp_at(F_READY, 1, "rst_ready", 0);
    exp_at(F_ERR,   0, "rst_err", 0);
    tick();
    rst = 1'b1;
    tick();

    // start and stop together in IDLE
    bus.start = 1; bus.stop = 1;
    exp_at(F_STATE, int'(S_IDLE), "start_stop_idle", 1);
    exp_at(F_READY, 1, "start_stop_ready", 1);
    tick();
    bus.start = 0; bus.stop = 0;
    tick();

    // Configure in IDLE (thr written together with start)
    exp_at(F_ERR, 0, "idle_wr_no_err", 1);
    cfg_write(CFG_PERSIST, 16'd4);
    cfg_write(CFG_CLR, 16'd8);
    cfg_write(CFG_REFRACT, 16'd256);
    tick();
    start_run(1'b1, 16'd100);
    do_warmup();

    // Persistence: hit only after four consecutive >= 100
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        exp_at(F_STATE, int'(S_MONITOR), "t3_monitor", 1);
        exp_at(F_ALARM, 0, "t3_no_alarm", 1);
      end else begin
        exp_at(F_STATE, int'(S_ALARM), "t3_alarm_state", 1);
        exp_at(F_ALARM, 1, "t3_alarm", 1);
        exp_at(F_CNT,   1, "t3_alarm_cnt", 1);
      end
      strobe(t3[i]);
    end

    // Clear: sum==thr resets the run; a negative sum counts as below
    for (int i = 0; i < 12; i++) begin
      if (i < 11) begin
        exp_at(F_STATE, int'(S_ALARM), "t4_alarm_hold", 1);
        exp_at(F_ALARM, 1, "t4_alarm_level", 1);
      end else begin
        exp_at(F_STATE, int'(S_REFRACT), "t4_refract", 1);
        exp_at(F_ALARM, 0, "t4_alarm_clear", 1);
      end
      strobe(t4[i]);
    end

    // Refractory: 256 high samples ignored
    for (int i = 0; i < 256; i++) begin
      if (i < 255) begin
        exp_at(F_STATE, int'(S_REFRACT), "t4_refract_hold", 1);
        if (i % 64 == 0) exp_at(F_ALARM, 0, "t4_refract_no_alarm", 1);
      end else begin
        exp_at(F_STATE, int'(S_MONITOR), "t4_back_monitor", 1);
      end
      strobe(500);
    end

    // Config write outside IDLE is dropped
    exp_at(F_ERR,   1, "t5_cfg_err", 1);
    exp_at(F_READY, 0, "t5_not_ready", 1);
    exp_at(F_ERR,   0, "t5_cfg_err_pulse", 2);
    cfg_write(CFG_THR, 16'd2047);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) exp_at(F_STATE, int'(S_MONITOR), "t5_monitor", 1);
      else begin
        exp_at(F_STATE, int'(S_ALARM), "t5_thr_kept_alarm", 1);
        exp_at(F_CNT,   2, "t5_alarm_cnt", 1);
      end
      strobe(120);
    end

    // Baseline loss in ALARM
    bus.base_valid = 6'h3B;
    exp_at(F_STATE, int'(S_WARMUP), "t6_loss_warmup", 1);
    exp_at(F_ALARM, 0, "t6_loss_alarm", 1);
    exp_at(F_CNT,   2, "t6_loss_cnt_kept", 1);
    exp_at(F_EN_N,  0, "t6_loss_en", 1);
    tick();
    bus.base_valid = 6'h3F;
    tick();
    do_warmup();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_at(F_CNT, 3, "t6_rewarm_alarm_cnt", 1);
      strobe(120);
    end

    // stop in ALARM
    bus.stop = 1;
    exp_at(F_ALARM, 0, "stop_alarm_low", 1);
    exp_at(F_STATE, int'(S_IDLE), "stop_idle", 1);
    exp_at(F_CNT,   3, "stop_cnt_kept", 1);
    exp_at(F_READY, 1, "stop_ready", 1);
    exp_at(F_EN_N,  1, "stop_en_n", 1);
    tick();
    bus.stop = 0;

    // Zero counts behave as 1; drive alarm_cnt into saturation
    cfg_write(CFG_PERSIST, 16'd0);
    cfg_write(CFG_CLR, 16'd0);
    cfg_write(CFG_REFRACT, 16'd0);
    tick();
    start_run(1'b0, 16'd0);
    do_warmup();
    for (int i = 0; i < 256; i++) begin
      exp_at(F_STATE, int'(S_ALARM), "sat_alarm", 1);
      if (i == 0)   exp_at(F_CNT, 1, "sat_cnt_first", 1);
      if (i == 254) exp_at(F_CNT, 255, "sat_cnt_255", 1);
      if (i == 255) exp_at(F_CNT, 255, "sat_cnt_hold", 1);
      strobe(200);
      exp_at(F_STATE, int'(S_REFRACT), "sat_refract", 1);
      strobe(0);
      exp_at(F_STATE, int'(S_MONITOR), "sat_monitor", 1);
      strobe(0);
    end
    exp_at(F_STATE, int'(S_ALARM), "t1_in_alarm", 1);
    exp_at(F_CNT,   255, "sat_cnt_257", 1);
    strobe(200);

    // Asynchronous reset in ALARM, checked before the next clock edge
    rst = 1'b0;
    exp_at(F_STATE, 0, "t1_state", 0);
    exp_at(F_ALARM, 0, "t1_alarm", 0);
    exp_at(F_CNT,   0, "t1_cnt", 0);
    exp_at(F_EN_N,  1, "t1_en_n", 0);
    exp_at(F_CLR,   0, "t1_clr", 0);
    exp_at(F_READY, 1, "t1_ready", 0);
    exp_at(F_ERR,   0, "t1_err", 0);
    tick();
    rst = 1'b1;
    tick();
    exp_at(F_STATE, 0, "t1_after_release", 0);
    repeat (3) tick();

    if (q.size() != 0) begin
      $display("FAIL leftover_checks: got %0d unchecked, expected 0", q.size());
      checks += q.size();
      errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
